// File: rtl/seq_ctrl_pkg.sv
// Shared types, defaults and helpers for the serial stream controller and its match core.
package seq_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         HIST_W      = 8;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_0110;
    localparam logic [3:0] DEF_LEN     = 4'd3;

    // Pattern length is stored already clamped to 1..HIST_W.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len == 4'd0) begin
            return 4'd1;
        end
        if (len > 4'(HIST_W)) begin
            return 4'(HIST_W);
        end
        return len;
    endfunction

    function automatic logic [HIST_W-1:0] len_mask(input logic [3:0] len);
        logic [HIST_W:0] m;
        m = ((HIST_W+1)'(1) << len) - (HIST_W+1)'(1);
        return m[HIST_W-1:0];
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, masked pattern compare, registered match pulse, saturating
// match counter and sticky threshold interrupt.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic [7:0]         pattern,
    input  logic [3:0]         len,
    input  logic [CNT_W-1:0]   thresh,
    input  logic               irq_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq
);

    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_next;
    logic [HIST_W-1:0] mask;
    logic [3:0]        fill;
    logic [3:0]        fill_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              hit;

    always_comb begin
        hist_next = {hist[HIST_W-2:0], bit_in};
        fill_next = (fill == 4'(HIST_W)) ? fill : fill + 4'd1;
        mask      = len_mask(len);
        cnt_inc   = match_cnt + CNT_W'(1);
    end

    // hit marks the cycle in which the counter has just stepped onto the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            hit       <= 1'b0;
            irq       <= 1'b0;
        end else if (clr) begin
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            hit       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            match <= 1'b0;
            if (bit_valid) begin
                hist  <= hist_next;
                fill  <= fill_next;
                match <= ((hist_next & mask) == (pattern & mask)) && (fill_next >= len);
            end
            hit <= 1'b0;
            if (match && (match_cnt != '1)) begin
                match_cnt <= cnt_inc;
                hit       <= (thresh != '0) && (cnt_inc == thresh);
            end
            irq <= hit || (irq && !irq_clr);
        end
    end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word-to-bit serializer with valid/ready input, pattern configuration and
// the match core that watches the serialized stream.
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             cfg_err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_clr,
    output logic             busy,
    output logic             state
);

    localparam int IDX_W = $clog2(W);

    // Handshake: a word moves only when s_valid and s_ready are both high at
    // a rising edge; s_data is captured on that edge. s_ready is registered
    // and is high in IDLE and on the final bit of a word.
    state_t             st;
    logic [W-1:0]       sreg;
    logic [IDX_W-1:0]   idx;
    logic               ready;
    logic [7:0]         pat;
    logic [3:0]         len;
    logic [CNT_W-1:0]   thr;
    logic               xfer;
    logic               cfg_ok;

    assign xfer      = s_valid && ready;
    assign cfg_ok    = cfg_we && (st == IDLE) && !xfer;
    assign s_ready   = ready;
    assign bit_valid = (st == SHIFT);
    assign busy      = (st == SHIFT);
    assign state     = st;
    assign bit_out   = (st == SHIFT) && sreg[W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            sreg  <= '0;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (xfer) begin
                        sreg  <= s_data;
                        idx   <= IDX_W'(W - 1);
                        st    <= SHIFT;
                        ready <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (idx == '0) begin
                        // Back-to-back reload keeps bit_valid high with no bubble.
                        if (xfer) begin
                            sreg  <= s_data;
                            idx   <= IDX_W'(W - 1);
                            ready <= 1'b0;
                        end else begin
                            st    <= IDLE;
                            ready <= 1'b1;
                        end
                    end else begin
                        sreg  <= {sreg[W-2:0], 1'b0};
                        idx   <= idx - IDX_W'(1);
                        ready <= (idx == IDX_W'(1));
                    end
                end
                default: begin
                    st    <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat     <= DEF_PATTERN;
            len     <= DEF_LEN;
            thr     <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                pat <= cfg_pattern;
                len <= clamp_len(cfg_len);
                thr <= cfg_thresh;
            end
        end
    end

    seq_match_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (cfg_ok),
        .bit_in    (bit_out),
        .bit_valid (bit_valid),
        .pattern   (pat),
        .len       (len),
        .thresh    (thr),
        .irq_clr   (irq_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .irq       (irq)
    );

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Self-checking bench for seq_stream_ctrl: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_seq_stream_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             cfg_err;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [W-1:0]     s_data = '0;
    logic             bit_out;
    logic             bit_valid;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             irq;
    logic             irq_clr = 1'b0;
    logic             busy;
    logic             state;

    int total = 0;
    int bad   = 0;

    seq_stream_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
        .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending bits of accepted words, recent bit history,
    // current configuration and the expected value of each output.
    bit         mq[$];
    bit         mh[$];
    logic [7:0] m_pat;
    int         m_len, m_thr, m_cnt, m_prev;
    bit         m_match, m_irq, m_rdy, m_err;

    task automatic model_reset();
        mq.delete();
        mh.delete();
        m_pat = 8'b0000_0110; m_len = 3; m_thr = 0;
        m_cnt = 0; m_prev = 0;
        m_match = 0; m_irq = 0; m_rdy = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit xfer, idle, acc, nm, b, became;
        xfer = s_valid && m_rdy;
        idle = (mq.size() == 0);
        acc  = cfg_we && idle && !xfer;
        nm   = 0;
        if (!idle) begin
            b = mq.pop_front();
            mh.push_back(b);
            if (mh.size() > 8) void'(mh.pop_front());
            if (mh.size() >= m_len) begin
                nm = 1;
                for (int i = 0; i < m_len; i++)
                    if (mh[mh.size() - 1 - i] != m_pat[i]) nm = 0;
            end
        end
        if (xfer) for (int i = W - 1; i >= 0; i--) mq.push_back(s_data[i]);
        m_rdy  = (mq.size() <= 1);
        became = (m_thr != 0) && (m_cnt == m_thr) && (m_prev != m_cnt);
        m_irq  = became || (m_irq && !irq_clr);
        m_prev = m_cnt;
        if (m_match && m_cnt < CMAX) m_cnt++;
        m_match = nm;
        m_err   = cfg_we && !acc;
        if (acc) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
            m_thr = int'(cfg_thresh);
            mh.delete();
            m_cnt = 0; m_prev = 0; m_irq = 0; m_match = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("bit_valid", bit_valid, 32'(mq.size() > 0));
        chk("busy",      busy,      32'(mq.size() > 0));
        chk("state",     state,     32'(mq.size() > 0));
        chk("bit_out",   bit_out,   32'((mq.size() > 0) ? mq[0] : 1'b0));
        chk("s_ready",   s_ready,   32'(m_rdy));
        chk("match",     match,     32'(m_match));
        chk("match_cnt", match_cnt, 32'(m_cnt));
        chk("irq",       irq,       32'(m_irq));
        chk("cfg_err",   cfg_err,   32'(m_err));
        if (!rst) model_step();
    end

    int match_seen, irq_cycles, err_seen, bv_cycles, rdy_bv_cycles;

    always @(negedge clk) begin
        if (match) match_seen++;
        if (irq) irq_cycles++;
        if (cfg_err) err_seen++;
        if (bit_valid) bv_cycles++;
        if (bit_valid && s_ready) rdy_bv_cycles++;
    end

    task automatic clear_mon();
        match_seen = 0; irq_cycles = 0; err_seen = 0; bv_cycles = 0; rdy_bv_cycles = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit hold);
        int  n;
        bit  r;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            r = s_ready;
            tick();
            if (r) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL send_timeout: s_ready never high, want handshake");
                break;
            end
        end
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=1 want 0");
        end
        repeat (3) tick();
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic [CNT_W-1:0] t);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_thresh  = t;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", match_cnt, 0);
        rst = 1'b0;
        tick();

        // Default "110" on 1101_1011
        clear_mon();
        send_word(8'b1101_1011, 0);
        wait_idle();
        chk("t1_cnt", match_cnt, 2);
        chk("t1_pulses", match_seen, 2);

        // Overlapping "1010"
        cfg_write(8'b0000_1010, 4'd4, 16'd0);
        clear_mon();
        send_word(8'b1010_1010, 0);
        wait_idle();
        chk("t2_cnt", match_cnt, 3);
        chk("t2_pulses", match_seen, 3);

        // Back-to-back words, match across the boundary
        cfg_write(8'b0000_0110, 4'd3, 16'd0);
        clear_mon();
        send_word(8'h03, 1);
        send_word(8'h00, 0);
        wait_idle();
        chk("t3_cnt", match_cnt, 1);
        chk("t3_bv_cycles", bv_cycles, 16);
        chk("t3_ready_in_shift", rdy_bv_cycles, 2);

        // Threshold interrupt, clear, and set winning over clear
        cfg_write(8'b0000_0110, 4'd3, 16'd2);
        send_word(8'b1101_1011, 0);
        wait_idle();
        chk("t4_irq_set", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("t4_irq_clr", irq, 0);
        cfg_write(8'b0000_0110, 4'd3, 16'd2);
        clear_mon();
        irq_clr = 1'b1;
        send_word(8'b1101_1011, 0);
        wait_idle();
        irq_clr = 1'b0;
        chk("t4_set_wins", irq_cycles, 1);

        // Rejected write during SHIFT
        cfg_write(8'b0000_0110, 4'd3, 16'd0);
        clear_mon();
        send_word(8'b1101_1011, 0);
        cfg_write(8'b0000_0101, 4'd3, 16'd0);
        wait_idle();
        chk("t5_err", err_seen, 1);
        chk("t5_cnt", match_cnt, 2);

        // Reset in the middle of a word
        cfg_write(8'b0000_1111, 4'd4, 16'd0);
        send_word(8'hFF, 0);
        wait_idle();
        chk("t6_pre_cnt", match_cnt, 5);
        send_word(8'b1101_1011, 0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t6_bit_valid", bit_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_state", state, 0);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_cnt", match_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        clear_mon();
        send_word(8'b1101_1011, 0);
        wait_idle();
        chk("t6_default_cnt", match_cnt, 2);

        // Random traffic
        cfg_write(8'($urandom), 4'($urandom_range(1, 4)), 16'($urandom_range(1, 4)));
        for (int c = 0; c < 3000; c++) begin
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = W'($urandom);
            irq_clr     = ($urandom_range(0, 9) == 0);
            cfg_we      = ($urandom_range(0, 29) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            cfg_thresh  = 16'($urandom_range(0, 5));
            tick();
        end
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        irq_clr = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Controller that feeds a bit-serial pattern detector from a parallel word stream and configures the detector's pattern.
- Accepts W-bit words over a valid/ready handshake and serializes them MSB-first, one bit per clock.
- Matches a programmable pattern of up to 8 bits, overlap allowed; default after reset is "110".
- Counts matches and raises a sticky interrupt at a programmable threshold. Sits between the host/bus side and the detector datapath.

Parameters:
- W, 8, input word width in bits (2..32).
- CNT_W, 16, width of the match counter and threshold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  8  pattern bits, LSB = most recent bit.
- cfg_len  in  4  pattern length, 1..8.
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq.
- cfg_err  out  1  one-cycle pulse when a cfg_we is rejected.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  W  input word.
- bit_out  out  1  serialized bit (detector input).
- bit_valid  out  1  bit_out is valid this cycle.
- match  out  1  one-cycle pulse, pattern detected.
- match_cnt  out  CNT_W  saturating match count.
- irq  out  1  sticky threshold interrupt.
- irq_clr  in  1  clears irq.
- busy  out  1  high while in SHIFT.
- state  out  1  FSM state, 0=IDLE, 1=SHIFT (debug).

Behaviour:
- Reset (async, immediate):
  - All outputs are 0; state = IDLE.
  - History and fill count are 0.
  - Config returns to pattern=8'b0000_0110, len=3, thresh=0.
- FSM states:
  - IDLE:
    - s_ready=1. On s_valid&&s_ready, latch s_data into the shift register, set bit index=W-1, go to SHIFT.
  - SHIFT:
    - bit_valid=1 every cycle; bit_out = shift register MSB.
    - Bit index decrements each cycle.
    - On the last bit (index 0), s_ready=1. If s_valid, reload and stay in SHIFT with no bubble; else go to IDLE.
    - s_ready=0 on all other SHIFT cycles.
- Handshake:
  - A transfer occurs only when s_valid&&s_ready in the same cycle.
  - s_data is sampled at that edge. Dropping s_valid without a transfer is legal.
- Detection:
  - Each cycle with bit_valid=1, the edge shifts bit_out into the 8-bit history (hist <= {hist[6:0],bit_out}).
  - The same edge increments fill, saturating at 8.
  - match is registered. Compare the updated history with mask = (1<<cfg_len)-1: (hist & mask) == (cfg_pattern & mask), gated by fill >= cfg_len.
  - The result pulses match in the cycle after the bit's bit_valid cycle.
  - Overlapping matches count. History persists across word boundaries and IDLE gaps.
- Counter:
  - match_cnt increments on each match and saturates at all-ones.
- irq:
  - Set in the cycle after match_cnt becomes equal to cfg_thresh (thresh != 0).
  - Cleared by irq_clr. If set and clear occur in the same cycle, set wins.
- Config:
  - cfg_we is accepted only in IDLE with no transfer that cycle.
  - An accepted write loads pattern/len/thresh and clears hist, fill, match_cnt and irq.
  - A write that is not accepted (including in SHIFT) is ignored, and cfg_err pulses for 1 cycle.
  - cfg_len=0 is clamped to 1; cfg_len>8 is clamped to 8.
- Reset mid-SHIFT aborts the word; the remaining bits are discarded.

Decomposition:
- Package seq_ctrl_pkg:
  - State enum (IDLE, SHIFT).
  - DEF_PATTERN=8'b0000_0110, DEF_LEN=3.
  - HIST_W=8.
- One natural sub-module: seq_match_core, holding the history, fill, mask compare, registered match, counter and irq.
- Top level keeps the FSM, serializer and config.

Test Plan:
1. Reset, default cfg, word 8'b1101_1011 → bit_out sequence 1,1,0,1,1,0,1,1 on 8 consecutive bit_valid cycles; match pulses after bits 3 and 6; match_cnt=2.
2. cfg pattern=8'b0000_1010, len=4; word 8'b1010_1010 → 3 overlapping matches (after bits 4, 6 and 8); match_cnt=3.
3. Default cfg, words 8'h03 then 8'h00 with s_valid held → bit_valid high for 16 contiguous cycles; s_ready high only on cycles 8 and 16; one match spanning the boundary; match_cnt=1.
4. cfg thresh=2, default pattern, word 8'b1101_1011 → irq rises the cycle after the 2nd match; irq_clr pulse → irq=0; irq_clr together with a set → irq stays 1.
5. cfg_we during SHIFT → cfg_err pulses 1 cycle; pattern is unchanged and subsequent matches still follow "110".
6. Assert rst during bit 4 of a word → all outputs 0 immediately (async); the next word matches against default "110" from an empty history.
